// File: rtl/pbit_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// pbit_sweep_scheduler
//
// Purpose:
//    Sequences Gibbs-style updates of NUM_PBITS p-bits through one shared,
//    time-multiplexed update datapath. One request is in flight at a time,
//    issued in index order 0..NUM_PBITS-1. Each returned bit is committed into
//    the p-bit state register. update_cycle_done pulses once per completed
//    sweep. Clamped p-bits are never sent to the datapath; they are forced to
//    clamp_val every cycle.
//
// Ports:
//    clk               system clock, rising edge
//    reset             synchronous, active-high reset
//    run               level enable; high = keep sweeping
//    clamp_mask        1 = p-bit clamped (skipped, forced to clamp_val)
//    clamp_val         value forced on clamped p-bits
//    upd_req           request to the shared update datapath
//    upd_idx           index of the p-bit being updated
//    upd_state         state snapshot for the datapath (= pbit_out)
//    upd_ready         datapath accepts request when upd_req && upd_ready
//    upd_valid         datapath result strobe (honoured only while waiting)
//    upd_bit           new value for p-bit upd_idx
//    pbit_out          current p-bit state vector
//    update_cycle_done one-cycle pulse, full sweep committed
//    sweep_count       completed sweeps, wraps 2^32-1 -> 0
//    busy              high in any state other than IDLE
// -----------------------------------------------------------------------------
module pbit_sweep_scheduler #(
   parameter int                   NUM_PBITS  = 8,
   parameter int                   IDX_W      = $clog2(NUM_PBITS),
   parameter logic [NUM_PBITS-1:0] INIT_STATE = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [NUM_PBITS-1:0] clamp_mask,
   input  logic [NUM_PBITS-1:0] clamp_val,
   output logic                 upd_req,
   output logic [IDX_W-1:0]     upd_idx,
   output logic [NUM_PBITS-1:0] upd_state,
   input  logic                 upd_ready,
   input  logic                 upd_valid,
   input  logic                 upd_bit,
   output logic [NUM_PBITS-1:0] pbit_out,
   output logic                 update_cycle_done,
   output logic [31:0]          sweep_count,
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PBITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t               state_r;
   logic [IDX_W-1:0]     idx_r;
   logic [NUM_PBITS-1:0] pbit_r;
   logic                 upd_req_r;
   logic                 done_r;
   logic                 busy_r;
   logic [31:0]          sweep_count_r;

   logic                 last_idx_s;
   logic [IDX_W-1:0]     next_idx_s;
   logic                 commit_s;
   logic                 advance_s;
   logic [NUM_PBITS-1:0] commit_vec_s;
   logic [NUM_PBITS-1:0] pbit_next_s;

   // Index sequencing: wrap to 0 after the last p-bit.
   always_comb begin
      last_idx_s = (idx_r == LAST_IDX);
      if (last_idx_s) begin
         next_idx_s = {IDX_W{1'b0}};
      end else begin
         next_idx_s = idx_r + IDX_ONE;
      end
   end

   // Commit/advance decode. In ISSUE, a cleared upd_req_r marks a clamped
   // index: that slot is a one-cycle skip instead of a datapath request.
   always_comb begin
      commit_s  = (state_r == ST_WAIT) && upd_valid;
      advance_s = commit_s || ((state_r == ST_ISSUE) && !upd_req_r);
   end

   // Next p-bit vector: the returned bit is merged first, then the clamp
   // override is applied, so a clamped bit wins over any committed value.
   always_comb begin
      commit_vec_s = pbit_r;
      if (commit_s) begin
         commit_vec_s[idx_r] = upd_bit;
      end else begin
         commit_vec_s = pbit_r;
      end
      pbit_next_s = (commit_vec_s & ~clamp_mask) | (clamp_val & clamp_mask);
   end

   // Sweep FSM with registered request, done pulse, busy and sweep counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         idx_r         <= {IDX_W{1'b0}};
         pbit_r        <= INIT_STATE;
         upd_req_r     <= 1'b0;
         done_r        <= 1'b0;
         busy_r        <= 1'b0;
         sweep_count_r <= 32'd0;
      end else begin
         pbit_r <= pbit_next_s;
         done_r <= 1'b0;

         case (state_r)
            ST_IDLE: begin
               // Resume at the saved index; the request is pre-decided here
               // so upd_req is registered and valid in the first ISSUE cycle.
               if (run) begin
                  state_r   <= ST_ISSUE;
                  upd_req_r <= ~clamp_mask[idx_r];
                  busy_r    <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // Request held stable until accepted.
               if (upd_req_r && upd_ready) begin
                  state_r   <= ST_WAIT;
                  upd_req_r <= 1'b0;
               end
            end
            ST_WAIT: begin
               // Wait indefinitely for upd_valid; the commit is handled by
               // the advance logic below.
               upd_req_r <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               upd_req_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase

         // Index boundary: the only point where run is re-evaluated, so an
         // in-flight request always commits before the FSM idles.
         if (advance_s) begin
            idx_r <= next_idx_s;
            if (last_idx_s) begin
               done_r        <= 1'b1;
               sweep_count_r <= sweep_count_r + 32'd1;
            end
            if (run) begin
               state_r   <= ST_ISSUE;
               upd_req_r <= ~clamp_mask[next_idx_s];
               busy_r    <= 1'b1;
            end else begin
               state_r   <= ST_IDLE;
               upd_req_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         end
      end
   end

   assign upd_req           = upd_req_r;
   assign upd_idx           = idx_r;
   assign upd_state         = pbit_r;
   assign pbit_out          = pbit_r;
   assign update_cycle_done = done_r;
   assign sweep_count       = sweep_count_r;
   assign busy              = busy_r;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pbit_sweep_scheduler
//
// Self-checking bench for pbit_sweep_scheduler (NUM_PBITS=4, INIT_STATE=0).
// A datapath model with fixed latency answers every accepted request; the
// expected request index order is queued up front and popped on each accept.
// A table of clamp configurations checks sweep result, period and count;
// hand-written sequences cover ready stalls, run drop, reset mid-update and
// sweep counter wrap.
// -----------------------------------------------------------------------------
module tb_pbit_sweep_scheduler;

   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic [N-1:0]  clamp_mask;
   logic [N-1:0]  clamp_val;
   logic          upd_req;
   logic [IW-1:0] upd_idx;
   logic [N-1:0]  upd_state;
   logic          upd_ready;
   logic          upd_valid;
   logic          upd_bit;
   logic [N-1:0]  pbit_out;
   logic          update_cycle_done;
   logic [31:0]   sweep_count;
   logic          busy;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   idx_q[$];
   bit   pending;
   int   pend_cnt;
   logic ret_bit;
   int   hold_left;
   bit   hold_armed;
   int   hold_idx;
   bit   saw_idx1;

   typedef struct {
      logic [N-1:0] mask;
      logic [N-1:0] cval;
      logic         ret;
      logic [N-1:0] exp_pbit;
      int           exp_period;
   } vec_t;

   vec_t vecs[5];

   pbit_sweep_scheduler #(
      .NUM_PBITS (N),
      .IDX_W     (IW),
      .INIT_STATE(4'b0000)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .run              (run),
      .clamp_mask       (clamp_mask),
      .clamp_val        (clamp_val),
      .upd_req          (upd_req),
      .upd_idx          (upd_idx),
      .upd_state        (upd_state),
      .upd_ready        (upd_ready),
      .upd_valid        (upd_valid),
      .upd_bit          (upd_bit),
      .pbit_out         (pbit_out),
      .update_cycle_done(update_cycle_done),
      .sweep_count      (sweep_count),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic raw_edge();
      @(posedge clk);
      #1;
   endtask

   // One clock with the datapath model: count down the in-flight request,
   // optionally stall ready, pop the expected index on every accept.
   task automatic step();
      logic v;
      raw_edge();
      v = 1'b0;
      if (pending) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            v       = 1'b1;
            pending = 1'b0;
         end
      end
      if (hold_left > 0 && (hold_armed || (upd_req === 1'b1 && int'(upd_idx) == hold_idx))) begin
         hold_armed = 1'b1;
         check("hold_req", 32'(upd_req), 32'd1);
         check("hold_idx", 32'(upd_idx), 32'(hold_idx));
         check("hold_nocommit", 32'(pbit_out), 32'h3);
         hold_left--;
         upd_ready = 1'b0;
      end else begin
         upd_ready = 1'b1;
      end
      if (upd_req === 1'b1 && upd_ready === 1'b1) begin
         if (upd_idx == 2'd1) saw_idx1 = 1'b1;
         if (idx_q.size() == 0) begin
            fail_now("unexpected_req");
         end else begin
            check("req_idx", 32'(upd_idx), 32'(idx_q.pop_front()));
         end
         pending  = 1'b1;
         pend_cnt = LAT;
      end
      upd_valid = v;
      upd_bit   = ret_bit;
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         cyc++;
         if (update_cycle_done === 1'b1) break;
      end
      if (update_cycle_done !== 1'b1) fail_now({name, "_timeout"});
   endtask

   task automatic push_sweeps(input logic [N-1:0] mask, input int n);
      for (int s = 0; s < n; s++) begin
         for (int i = 0; i < N; i++) begin
            if (!mask[i]) idx_q.push_back(i);
         end
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      run        = 1'b0;
      pending    = 1'b0;
      upd_valid  = 1'b0;
      upd_ready  = 1'b1;
      hold_left  = 0;
      hold_armed = 1'b0;
      idx_q.delete();
      raw_edge();
      reset = 1'b0;
   endtask

   initial begin
      int c;

      vecs[0] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 16};
      vecs[1] = '{4'b0101, 4'b0100, 1'b1, 4'b1110, 10};
      vecs[2] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 16};
      vecs[3] = '{4'b1010, 4'b1010, 1'b0, 4'b1010, 10};
      vecs[4] = '{4'b1111, 4'b1001, 1'b0, 4'b1001, 4};

      reset      = 1'b1;
      run        = 1'b0;
      clamp_mask = 4'b0000;
      clamp_val  = 4'b0000;
      upd_ready  = 1'b1;
      upd_valid  = 1'b0;
      upd_bit    = 1'b0;
      ret_bit    = 1'b0;
      pending    = 1'b0;
      pend_cnt   = 0;
      hold_left  = 0;
      hold_armed = 1'b0;
      hold_idx   = 0;
      saw_idx1   = 1'b0;

      // Reset state
      raw_edge();
      raw_edge();
      check("rst_pbit", 32'(pbit_out), 32'h0);
      check("rst_req", 32'(upd_req), 32'h0);
      check("rst_idx", 32'(upd_idx), 32'h0);
      check("rst_done", 32'(update_cycle_done), 32'h0);
      check("rst_count", sweep_count, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;

      // Table-driven clamp configurations
      for (int t = 0; t < 5; t++) begin
         clamp_mask = vecs[t].mask;
         clamp_val  = vecs[t].cval;
         do_reset();
         ret_bit = vecs[t].ret;
         push_sweeps(vecs[t].mask, 3);
         run = 1'b1;
         wait_done("tbl_first", c);
         check("tbl_first_cycles", 32'(c), 32'(vecs[t].exp_period + 1));
         check("tbl_pbit1", 32'(pbit_out), 32'(vecs[t].exp_pbit));
         check("tbl_state1", 32'(upd_state), 32'(vecs[t].exp_pbit));
         check("tbl_count1", sweep_count, 32'd1);
         wait_done("tbl_second", c);
         check("tbl_period", 32'(c), 32'(vecs[t].exp_period));
         check("tbl_pbit2", 32'(pbit_out), 32'(vecs[t].exp_pbit));
         check("tbl_count2", sweep_count, 32'd2);
      end

      // Ready held low for 5 cycles during the idx=2 request
      clamp_mask = 4'b0000;
      clamp_val  = 4'b0000;
      do_reset();
      ret_bit   = 1'b1;
      hold_idx  = 2;
      hold_left = 5;
      push_sweeps(4'b0000, 2);
      run = 1'b1;
      wait_done("stall", c);
      check("stall_cycles", 32'(c), 32'd22);
      check("stall_hold_used", 32'(hold_left), 32'd0);
      check("stall_pbit", 32'(pbit_out), 32'hF);
      check("stall_count", sweep_count, 32'd1);

      // run dropped while waiting on idx=1
      do_reset();
      ret_bit  = 1'b1;
      saw_idx1 = 1'b0;
      push_sweeps(4'b0000, 2);
      run = 1'b1;
      for (int k = 0; k < 50 && !saw_idx1; k++) step();
      check("rundrop_seen_idx1", 32'(saw_idx1), 32'd1);
      run = 1'b0;
      for (int k = 0; k < 20 && busy !== 1'b0; k++) step();
      check("rundrop_busy", 32'(busy), 32'd0);
      check("rundrop_pbit", 32'(pbit_out), 32'h3);
      check("rundrop_idx", 32'(upd_idx), 32'd2);
      for (int k = 0; k < 3; k++) step();
      check("rundrop_idle_req", 32'(upd_req), 32'd0);
      check("rundrop_idle_busy", 32'(busy), 32'd0);
      run = 1'b1;
      wait_done("rundrop_resume", c);
      check("rundrop_pbit_done", 32'(pbit_out), 32'hF);
      check("rundrop_count", sweep_count, 32'd1);

      // Reset in WAIT, then a stale upd_valid
      do_reset();
      ret_bit = 1'b1;
      push_sweeps(4'b0000, 1);
      run = 1'b1;
      for (int k = 0; k < 20 && !pending; k++) step();
      check("rstwait_accepted", 32'(pending), 32'd1);
      step();
      check("rstwait_in_wait_busy", 32'(busy), 32'd1);
      reset     = 1'b1;
      run       = 1'b0;
      pending   = 1'b0;
      upd_valid = 1'b0;
      raw_edge();
      reset     = 1'b0;
      upd_valid = 1'b1;
      upd_bit   = 1'b1;
      raw_edge();
      upd_valid = 1'b0;
      raw_edge();
      check("rstwait_pbit", 32'(pbit_out), 32'h0);
      check("rstwait_idx", 32'(upd_idx), 32'd0);
      check("rstwait_count", sweep_count, 32'd0);
      check("rstwait_busy", 32'(busy), 32'd0);
      check("rstwait_req", 32'(upd_req), 32'd0);

      // All clamped, sweep counter wrap
      clamp_mask = 4'b1111;
      clamp_val  = 4'b0000;
      do_reset();
      run = 1'b1;
      wait_done("wrap_first", c);
      force dut.sweep_count_r = 32'hFFFF_FFFF;
      release dut.sweep_count_r;
      wait_done("wrap_second", c);
      check("wrap_period", 32'(c), 32'd4);
      check("wrap_count", sweep_count, 32'd0);
      check("wrap_pbit", 32'(pbit_out), 32'h0);
      run = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pbit_sweep_scheduler.md
Name: pbit_sweep_scheduler

Overview:
- Sequences Gibbs-style updates of NUM_PBITS p-bits through one shared, time-multiplexed update datapath (weighted sum, activation, RNG compare).
- Issues exactly one update request at a time, in index order 0..NUM_PBITS-1, and commits each returned bit into the state register.
- Pulses update_cycle_done once per completed sweep; the sampling bench and histogram logic consume this pulse.
- Supports clamped (fixed-value) p-bits for conditional inference.

Parameters:
NUM_PBITS, 8, number of p-bits in the shared update schedule (>=2)
IDX_W, $clog2(NUM_PBITS), width of the p-bit index
INIT_STATE, '0, pbit_out value loaded on reset (NUM_PBITS bits)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level enable; high = keep sweeping
clamp_mask  in  NUM_PBITS  1 = p-bit clamped, never sent to datapath
clamp_val  in  NUM_PBITS  value forced on clamped p-bits
upd_req  out  1  request to shared update datapath
upd_idx  out  IDX_W  index of p-bit being updated
upd_state  out  NUM_PBITS  state snapshot for the datapath (= pbit_out)
upd_ready  in  1  datapath accepts request when upd_req && upd_ready
upd_valid  in  1  datapath result strobe
upd_bit  in  1  new value for p-bit upd_idx
pbit_out  out  NUM_PBITS  current p-bit state vector
update_cycle_done  out  1  one-cycle pulse, full sweep committed
sweep_count  out  32  completed sweeps, wraps 2^32-1 -> 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, idx=0, pbit_out=INIT_STATE with clamped bits overridden by clamp_val on the first post-reset edge, upd_req=0, update_cycle_done=0, sweep_count=0, busy=0. Reset mid-update abandons the in-flight request; a later upd_valid is ignored.
- Clamp: each cycle, pbit_out[i] <= clamp_val[i] wherever clamp_mask[i]=1; this is registered, so pbit_out reflects a change on the next edge. A clamped bit takes priority over any committed upd_bit.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: when run=1, go to ISSUE with idx unchanged (resume point).
- ISSUE, idx clamped: no request; spend one cycle and advance idx as in the commit rule below.
- ISSUE, idx not clamped: upd_req=1 and upd_idx=idx. upd_req and upd_idx stay stable until upd_ready. On upd_req && upd_ready, go to WAIT.
- WAIT: upd_req=0. On upd_valid, pbit_out[idx] <= upd_bit and idx advances. No timeout; datapath latency is arbitrary (>=1 cycle).
- upd_valid outside WAIT is ignored.
- Advance rule:
  - If idx = NUM_PBITS-1: idx <= 0, update_cycle_done <= 1 on the same edge as the final commit (so pbit_out already holds the full sweep while done is high), sweep_count++.
  - Otherwise idx++.
  - After advancing, next state is ISSUE if run=1, else IDLE.
- run deassert: takes effect only at an index boundary. Any in-flight request completes and commits before entering IDLE.
- All bits clamped: a sweep takes NUM_PBITS cycles with no requests; update_cycle_done still pulses.
- Throughput, no clamps, datapath latency L (accept to valid): one update per L+1 cycles when upd_ready=1 (one ISSUE cycle plus L WAIT cycles).
- upd_state is combinationally pbit_out; the datapath sees all previously committed bits.

Test Plan:
- NUM_PBITS=4, INIT_STATE=0, no clamps, datapath model L=3 returning upd_bit=1, run held high -> upd_idx sequence 0,1,2,3; pbit_out=4'b1111 with update_cycle_done high in the same cycle; done pulse period 16 cycles; sweep_count=1.
- clamp_mask=4'b0101, clamp_val=4'b0100, datapath returns 1 -> requests only for idx 1,3; pbit_out=4'b1110 at done; sweep takes 2 skip cycles + 2x4 cycles = 10 cycles.
- upd_ready held low 5 cycles during idx=2 request -> upd_req/upd_idx stable all 5 cycles; no commit; sequence resumes correctly after ready.
- run dropped while in WAIT on idx=1 -> bit 1 commits, FSM enters IDLE with idx=2, busy=0; run re-raised -> next request has upd_idx=2.
- reset asserted in WAIT, then stale upd_valid pulse next cycle -> pbit_out=INIT_STATE, idx=0, no commit, sweep_count=0.
- clamp_mask=4'hF -> no upd_req ever; done pulses every 4 cycles; sweep_count wraps from 32'hFFFFFFFF to 0 when preloaded via force.
